// File: rtl/bitwise_pkg.sv
// Shared opcode constants for the bitwise unit.
// Imported by the evaluator and by anything that drives op.
package bitwise_pkg;

   localparam int OP_W = 3;

   localparam logic [OP_W-1:0] OP_AND  = 3'b000;
   localparam logic [OP_W-1:0] OP_OR   = 3'b001;
   localparam logic [OP_W-1:0] OP_XOR  = 3'b010;
   localparam logic [OP_W-1:0] OP_NAND = 3'b011;
   localparam logic [OP_W-1:0] OP_NOR  = 3'b100;
   localparam logic [OP_W-1:0] OP_XNOR = 3'b101;
   localparam logic [OP_W-1:0] OP_NOT  = 3'b110;
   localparam logic [OP_W-1:0] OP_SEL  = 3'b111;

endpackage

// File: rtl/bitwise_core.sv
// Combinational bitwise evaluator.
// Ports: a, b, c operands, op select; y result (c only used by OP_SEL).
module bitwise_core
   import bitwise_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   input  logic [OP_W-1:0]  op,
   output logic [WIDTH-1:0] y
);

   always_comb begin
      y = '0;
      unique case (op)
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         OP_XOR:  y = a ^ b;
         OP_NAND: y = ~(a & b);
         OP_NOR:  y = ~(a | b);
         OP_XNOR: y = ~(a ^ b);
         OP_NOT:  y = ~a;
         OP_SEL:  y = (a & c) | (b & ~c);
         default: y = '0;
      endcase
   end

endmodule

// File: rtl/bitwise_unit_pipe.sv
// Two-stage valid/ready pipeline around bitwise_core with a saturating
// transfer counter. Ports: in_valid/in_ready/op/a/b/c in, out_valid/out_ready/y/red_* out, count.
module bitwise_unit_pipe #(
   parameter int WIDTH   = 4,
   parameter int COUNT_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [2:0]         op,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic [WIDTH-1:0]   c,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   y,
   output logic               red_and,
   output logic               red_or,
   output logic               red_xor,
   output logic [COUNT_W-1:0] count
);

   localparam logic [COUNT_W-1:0] CNT_MAX = '1;

   logic             s1_v;
   logic             s2_v;
   logic             s1_rdy;
   logic             s2_rdy;
   logic [2:0]       s1_op;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;
   logic [WIDTH-1:0] s1_c;
   logic [WIDTH-1:0] core_y;

   // Ready chains backwards so a full pipe still advances when drained.
   assign s2_rdy    = ~s2_v | out_ready;
   assign s1_rdy    = ~s1_v | s2_rdy;
   assign in_ready  = s1_rdy;
   assign out_valid = s2_v;

   bitwise_core #(.WIDTH(WIDTH)) u_core (
      .a  (s1_a),
      .b  (s1_b),
      .c  (s1_c),
      .op (s1_op),
      .y  (core_y)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v  <= 1'b0;
         s1_op <= '0;
         s1_a  <= '0;
         s1_b  <= '0;
         s1_c  <= '0;
      end else if (s1_rdy) begin
         s1_v <= in_valid;
         // Operands only captured with a real transfer.
         if (in_valid) begin
            s1_op <= op;
            s1_a  <= a;
            s1_b  <= b;
            s1_c  <= c;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_v    <= 1'b0;
         y       <= '0;
         red_and <= 1'b0;
         red_or  <= 1'b0;
         red_xor <= 1'b0;
      end else if (s2_rdy) begin
         s2_v <= s1_v;
         if (s1_v) begin
            y       <= core_y;
            red_and <= &core_y;
            red_or  <= |core_y;
            red_xor <= ^core_y;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (s2_v && out_ready && count != CNT_MAX) begin
         count <= count + COUNT_W'(1);
      end
   end

endmodule

// File: tb/tb_bitwise_unit_pipe.sv
// Randomized scoreboard bench for bitwise_unit_pipe (WIDTH=4, COUNT_W=8).
// Expected results come from a queue model of the in-flight operations.
module tb_bitwise_unit_pipe;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] op;
   logic [3:0] a, b, c;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] y;
   logic       red_and, red_or, red_xor;
   logic [7:0] count;

   bitwise_unit_pipe #(.WIDTH(4), .COUNT_W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .c         (c),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y         (y),
      .red_and   (red_and),
      .red_or    (red_or),
      .red_xor   (red_xor),
      .count     (count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] y;
      int         vis;
   } item_t;

   item_t q[$];
   int    cyc   = 0;
   int    m_cnt = 0;
   int    nchk  = 0;
   int    npass = 0;

   task automatic chk(input string tag, input logic [7:0] got,
                      input logic [7:0] exp);
      nchk++;
      if (got === exp) npass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [3:0] ref_op(input logic [2:0] o,
      input logic [3:0] x, input logic [3:0] w, input logic [3:0] s);
      logic [3:0] r;
      r = 4'h0;
      for (int i = 0; i < 4; i++) begin
         case (o)
            3'd0: r[i] = x[i] && w[i];
            3'd1: r[i] = x[i] || w[i];
            3'd2: r[i] = x[i] != w[i];
            3'd3: r[i] = !(x[i] && w[i]);
            3'd4: r[i] = !(x[i] || w[i]);
            3'd5: r[i] = x[i] == w[i];
            3'd6: r[i] = !x[i];
            default: r[i] = s[i] ? x[i] : w[i];
         endcase
      end
      return r;
   endfunction

   function automatic logic [2:0] pop3(input logic [3:0] v);
      int n;
      n = v[0] + v[1] + v[2] + v[3];
      return {n == 4, n != 0, n % 2 == 1};
   endfunction

   // One cycle: drive at negedge, check, update model, cross posedge.
   task automatic step(input logic iv, input logic [2:0] o,
      input logic [3:0] ia, input logic [3:0] ib, input logic [3:0] ic,
      input logic ordy);
      logic ev, er;
      logic [2:0] rd;
      item_t it;
      in_valid  = iv;
      op        = o;
      a         = ia;
      b         = ib;
      c         = ic;
      out_ready = ordy;
      #1;
      ev = q.size() > 0 && cyc >= q[0].vis;
      er = q.size() < 2 || ordy;
      chk("out_valid", 8'(out_valid), 8'(ev));
      chk("in_ready", 8'(in_ready), 8'(er));
      chk("count", count, 8'(m_cnt));
      if (ev) begin
         rd = pop3(q[0].y);
         chk("y", 8'(y), 8'(q[0].y));
         chk("red", 8'({red_and, red_or, red_xor}), 8'(rd));
      end
      if (ev && ordy) begin
         void'(q.pop_front());
         if (m_cnt < 255) m_cnt++;
      end
      if (iv && er) begin
         it.y   = ref_op(o, ia, ib, ic);
         it.vis = cyc + 2;
         q.push_back(it);
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_ov"}, 8'(out_valid), 8'd0);
      chk({tag, "_rdy"}, 8'(in_ready), 8'd1);
      chk({tag, "_cnt"}, count, 8'd0);
      chk({tag, "_y"}, 8'(y), 8'd0);
      chk({tag, "_red"}, 8'({red_and, red_or, red_xor}), 8'd0);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      op        = '0;
      a         = '0;
      b         = '0;
      c         = '0;
      @(negedge clk);
      #1;
      chk_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Directed patterns.
      step(1, 3'b000, 4'b1000, 4'b1100, 4'b0000, 1);
      step(1, 3'b001, 4'b1000, 4'b1100, 4'b0000, 1);
      step(1, 3'b010, 4'b1000, 4'b1100, 4'b0000, 1);
      step(1, 3'b111, 4'b0010, 4'b1010, 4'b0011, 1);
      step(1, 3'b110, 4'b0000, 4'b0110, 4'b1001, 1);
      for (int i = 0; i < 3; i++) step(0, 3'b000, 4'h0, 4'h0, 4'h0, 1);
      chk("dir_y_not", 8'(y), 8'h0f);
      chk("dir_rand", 8'(red_and), 8'd1);

      // Stall with in_valid held, then drain.
      for (int i = 0; i < 4; i++)
         step(1, 3'(i), 4'(i + 3), 4'(9 - i), 4'h5, 0);
      for (int i = 0; i < 4; i++) step(0, 3'b000, 4'h0, 4'h0, 4'h0, 1);

      // Asynchronous reset between edges with a full pipe.
      for (int i = 0; i < 3; i++)
         step(1, 3'(i + 3), 4'(i * 5), 4'(i + 7), 4'hc, 0);
      #2;
      rst_n = 1'b0;
      #1;
      chk_zero("async_rst");
      q.delete();
      m_cnt = 0;
      @(posedge clk);
      cyc++;
      @(negedge clk);
      chk_zero("rst_hold");
      rst_n = 1'b1;

      // Random traffic long enough to saturate count.
      for (int i = 0; i < 700; i++) begin
         step($urandom_range(0, 9) < 8, 3'($urandom), 4'($urandom),
              4'($urandom), 4'($urandom), $urandom_range(0, 3) != 0);
      end
      for (int i = 0; i < 4; i++) step(0, 3'b000, 4'h0, 4'h0, 4'h0, 1);
      chk("count_sat", count, 8'd255);
      chk("drained", 8'(q.size()), 8'd0);

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule
